// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage divider and its bench.
package riscv_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/riscv_div_unit_if.sv
// Execute-stage <-> divider handshake: master is the execute stage, slave the divider.
interface riscv_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/riscv_div_unit_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            bit_in,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    // One extra bit: the shifted remainder can exceed XLEN bits before the subtract.
    logic [XLEN:0] trial;

    assign trial   = {rem_in, bit_in};
    assign q_bit   = (trial >= {1'b0, divisor});
    assign rem_out = q_bit ? XLEN'(trial - {1'b0, divisor}) : trial[XLEN-1:0];

endmodule

// File: rtl/riscv_div_unit.sv
// RV32M iterative restoring divider (DIV/DIVU/REM/REMU) for the execute stage.
// Optional DIV_FAST_SPECIAL_EN: div-by-zero, signed overflow and |a|<|b| finish in one cycle.
//
// state | meaning
// IDLE  | waiting for a divide op
// CALC  | one restoring step per cycle, count XLEN-1 down to 0
// FIX   | sign correction and quotient/remainder select
// DONE  | done pulse, result valid, a new op may be accepted
module riscv_div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    riscv_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    div_state_t      state;
    div_state_t      state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] result_q;
    logic [1:0]      f3_q;
    logic            sign_q;
    logic            sign_r;
    logic            div0;

    logic            idle_like;
    logic            accept;
    logic            busy_int;
    logic            is_signed_in;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] fix_res;

    // funct3[2] qualifies start so a stray multiply encoding can never stall the pipe.
    assign idle_like    = (state == IDLE) || (state == DONE);
    assign accept       = bus.start && bus.funct3[2] && !bus.flush && idle_like;
    assign is_signed_in = !bus.funct3[0];
    assign abs_a        = (is_signed_in && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    assign abs_b        = (is_signed_in && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

`ifdef DIV_FAST_SPECIAL_EN
    logic ovf_in;

    assign ovf_in = is_signed_in
                  && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.op_b == '1);

    always_comb begin
        fast_hit = 1'b1;
        fast_res = '0;
        if (bus.op_b == '0) begin
            fast_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (ovf_in) begin
            fast_res = bus.funct3[1] ? '0 : bus.op_a;
        end else if (abs_a < abs_b) begin
            fast_res = bus.funct3[1] ? bus.op_a : '0;
        end else begin
            fast_hit = 1'b0;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in  (rem),
        .divisor (divisor),
        .bit_in  (dividend[XLEN-1]),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // div0 leaves the all-ones quotient un-negated, matching the ISA result.
    assign q_fix   = (!f3_q[0] && sign_q && !div0) ? -quot : quot;
    assign r_fix   = (!f3_q[0] && sign_r) ? -rem : rem;
    assign fix_res = f3_q[1] ? r_fix : q_fix;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nx = fast_hit ? DONE : CALC;
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (bus.flush) begin
            state_nx = IDLE;
        end
    end

    always_comb begin
        busy_int  = (state == CALC) || (state == FIX);
        bus.busy  = busy_int;
        bus.done  = (state == DONE) && !bus.flush;
        bus.stall = accept || busy_int;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            quot     <= '0;
            f3_q     <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div0     <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            f3_q     <= bus.funct3[1:0];
            dividend <= abs_a;
            divisor  <= abs_b;
            rem      <= '0;
            quot     <= '0;
            sign_q   <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
            sign_r   <= bus.op_a[XLEN-1];
            div0     <= (bus.op_b == '0);
            count    <= CW'(XLEN - 1);
            if (fast_hit) begin
                result_q <= fast_res;
            end
        end else if (state == CALC && !bus.flush) begin
            rem      <= step_rem;
            quot     <= {quot[XLEN-2:0], step_q};
            dividend <= dividend << 1;
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end else if (state == FIX && !bus.flush) begin
            result_q <= fix_res;
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: directed ISA corner cases plus random ops vs a reference model.
module tb_riscv_div_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] last_exp = 32'h0;

    riscv_div_unit_if #(.XLEN(32)) bus ();

    riscv_div_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        bit sgn;
        sgn = (f3 == F3_DIV) || (f3 == F3_REM);
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        logic [31:0] ma;
        logic [31:0] mb;
        bit sgn;
        sgn = (f3 == F3_DIV) || (f3 == F3_REM);
        ma = (sgn && a[31]) ? 32'h0 - a : a;
        mb = (sgn && b[31]) ? 32'h0 - b : b;
        if (b == 32'h0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (ma < mb) return 1;
`endif
        return 34;
    endfunction

    // Presents one op for a single cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        #1 chk("stall_on_start", bus.stall, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int prof_bad);
        n = 1;
        prof_bad = 0;
        while (bus.done !== 1'b1 && n < 80) begin
            if (bus.busy !== 1'b1 || bus.stall !== 1'b1) prof_bad++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int n;
        int pb;
        exp = ref_res(f3, a, b);
        lat = ref_lat(f3, a, b);
        issue(f3, a, b);
        wait_done(n, pb);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, bus.result, exp);
        chk({tag, "_busy_prof"}, pb, 0);
        chk({tag, "_busy_done"}, bus.busy, 1'b0);
        chk({tag, "_stall_done"}, bus.stall, 1'b0);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.done, 1'b0);
        chk({tag, "_hold"}, bus.result, exp);
        last_exp = exp;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int pb;
        int cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;

        bus.start  = 1'b0;
        bus.funct3 = F3_DIV;
        bus.op_a   = 32'h0;
        bus.op_b   = 32'h0;
        bus.flush  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        run_op("div_12_3", F3_DIV, 32'd12, 32'd3);
        chk("div_12_3_const", last_exp, 32'd4);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("remu_fff9_2", F3_REMU, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_10_3", F3_DIVU, 32'd10, 32'd3);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div_5_0", F3_DIV, 32'd5, 32'd0);
        run_op("rem_5_0", F3_REM, 32'd5, 32'd0);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_m9_0", F3_DIV, 32'hFFFF_FFF7, 32'd0);
        run_op("remu_3_9", F3_REMU, 32'd3, 32'd9);

        // Flush during CALC: no done, result untouched, then a clean re-issue.
        issue(F3_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        chk("flush_done_before", bus.done, 1'b0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_stall", bus.stall, 1'b0);
        chk("flush_result", bus.result, last_exp);
        cnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("flush_no_done", cnt, 0);
        run_op("div_100_7", F3_DIV, 32'd100, 32'd7);

        // Back-to-back: new op accepted in the DONE cycle.
        issue(F3_REM, 32'd10, 32'd3);
        wait_done(n, pb);
        chk("b2b_first_res", bus.result, 32'd1);
        chk("b2b_first_lat", n, 34);
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd30;
        bus.op_b   = 32'd5;
        #1 chk("b2b_stall", bus.stall, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1'b1);
        wait_done(n, pb);
        chk("b2b_second_lat", n, 34);
        chk("b2b_second_res", bus.result, 32'd6);
        @(negedge clk);

        // start held while busy with changing operands must be ignored.
        issue(F3_DIVU, 32'd1000, 32'd7);
        cnt = 0;
        repeat (18) begin
            bus.start  = 1'b1;
            bus.funct3 = F3_DIV;
            bus.op_a   = $urandom;
            bus.op_b   = $urandom;
            #1 if (bus.stall !== 1'b1) cnt++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("held_stall", cnt, 0);
        wait_done(n, pb);
        chk("held_lat", 18 + n, 34);
        chk("held_res", bus.result, 32'd142);
        @(negedge clk);

        // Reset in the middle of CALC.
        issue(F3_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_result", bus.result, 32'h0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_stall", bus.stall, 1'b0);
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("midrst_no_done", cnt, 0);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = 32'h0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), f3, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
# riscv_div_unit

Iterative radix-2 restoring divider for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU). It sits in the execute stage of the pipelined CPU beside the single-cycle ALU/multiplier and takes operands after forwarding. It produces the writeback value consumed by the EX/MEM register and raises a stall so fetch, decode and execute hold while a division is in flight. It is the first multi-cycle execute resource in the pipeline.

## Interface
Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  execute stage presents a valid M-extension divide op (opcode 0110011, funct7 0000001, funct3[2]=1).
- funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  dividend (rs1, forwarded).
- op_b  input  XLEN  divisor (rs2, forwarded).
- flush  input  1  branch/jump redirect kills the op in flight.
- busy  output  1  iteration in progress.
- stall  output  1  hold IF/ID/EX, insert bubble into EX/MEM.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  quotient or remainder per funct3.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: if start, latch funct3; latch |op_a| and |op_b| for signed ops (raw values for unsigned); record sign_q = a[31]^b[31], sign_r = a[31], and div0 = (op_b==0). Go to CALC with count = XLEN-1.
- CALC: one restoring step per cycle, MSB first: rem = {rem, dividend_msb}; if rem >= divisor then subtract and set quotient bit. Decrement count; after count 0 go to FIX.
- FIX: quotient negated if signed && sign_q && !div0; remainder negated if signed && sign_r. Select quotient (funct3[1]=0) or remainder. Go to DONE.
- DONE: done=1, result driven. Return to IDLE; a start in DONE is accepted as in IDLE (back-to-back).
- Arithmetic results follow the RISC-V spec exactly:
  - x/0 gives quotient all-ones and remainder = dividend.
  - Signed 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
  - Both fall out of the iteration plus the div0 negation suppression.
- start asserted in CALC or FIX is ignored; the execute stage is stalled, so it re-presents the same op.
- flush in any state: next state IDLE, no done pulse, result unchanged. flush and start together in IDLE: flush wins, nothing accepted.
- result holds its last value until the next DONE.

## Timing
- Reset (rst=0 at posedge): state IDLE, busy 0, done 0, stall 0, result 0, count 0.
- Normal op, with start sampled at edge T:
  - busy high from T+1 through T+XLEN+1.
  - FIX occupies the cycle after XLEN CALC cycles.
  - done high and result valid during cycle T+XLEN+2 (34 cycles for XLEN=32).
  - busy is low in DONE.
- stall is combinational: (start && state∈{IDLE,DONE} && !flush) || state∈{CALC,FIX}. The EX/MEM register captures result in the done cycle, with stall low.
- Reset mid-operation aborts identically to flush and forces reset values.

## Configuration
- DIV_FAST_SPECIAL_EN defined: in IDLE, div0 or signed-overflow operands skip CALC/FIX and go straight to DONE with the spec result. done occurs at T+1, and stall is asserted only during the start cycle.
  - |op_a| < |op_b| (unsigned magnitude) also takes this path: quotient 0, remainder = op_a.
- Undefined: all operands take the full XLEN+2-cycle path; results are identical.

## Structure
- Shared package riscv_pkg holds:
  - funct3 constants F3_DIV/F3_DIVU/F3_REM/F3_REMU;
  - OPC_RTYPE and F7_MEXT;
  - typedef enum div_state_t {IDLE, CALC, FIX, DONE}.
- One sub-module, div_step: combinational single restoring step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit. Instantiated once.

## Test plan
- DIV 12/3 -> result 4 at T+34, done single pulse, stall high T..T+33.
- REM -7/2 -> -1; REMU 0xFFFFFFF9/2 -> 1; DIVU 10/3 -> 3; DIV -7/2 -> -3.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same -> 0. With DIV_FAST_SPECIAL_EN, each completes at T+1.
- flush at cycle T+10 of DIV 100/7 -> no done, back in IDLE at T+11. A following start DIV 100/7 -> 14.
- Back-to-back: start held in the DONE cycle of REM 10/3 (=1) with new operands DIVU 30/5 -> 6, 34 cycles later with no gap state.
- rst=0 during CALC -> all outputs 0 next cycle. start is ignored while busy, and the operand change is not latched.
